// File: rtl/sram_line_ctrl.sv
// Line-granular initiator for a single-port byte SRAM: serializes whole-line reads and writes
// into byte accesses with a fixed read latency and returns the assembled line on a held response.
module sram_line_ctrl #(
  parameter int unsigned LINE_BYTES   = 4,
  parameter int unsigned SRAM_LATENCY = 2,
  parameter int unsigned ADDR_W       = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*LINE_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*LINE_BYTES-1:0] resp_rdata,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [7:0]              sram_din,
  output logic                    sram_wen,
  output logic                    sram_sense_en,
  input  logic [7:0]              sram_dout
);

  localparam int unsigned IdxW  = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned WaitW = $clog2(SRAM_LATENCY + 1);
  localparam int unsigned LineW = 8 * LINE_BYTES;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(LINE_BYTES - 1);
  localparam logic [WaitW-1:0]  LastWait  = WaitW'(SRAM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StReadIssue, StReadWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LineW-1:0]   wdata_q, wdata_d;
  logic [LineW-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic               wen_q, wen_d;
  logic               sense_q, sense_d;
  logic               accept;
  logic               capture;

  // req_ready is the only combinational output; it drops for the whole reset cycle.
  assign req_ready  = (state_q == StIdle) && !rst;
  assign accept     = req_valid && req_ready;
  assign capture    = (state_q == StReadWait) && (wait_q == LastWait);

  assign resp_valid    = (state_q == StResp);
  assign resp_rdata    = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_din      = din_q;
  assign sram_wen      = wen_q;
  assign sram_sense_en = sense_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wen_q   <= 1'b0;
      sense_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
      sense_q <= sense_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          base_d  = req_addr & AlignMask;
          wdata_d = req_wdata;
          rdata_d = '0;
          idx_d   = '0;
          state_d = req_write ? StWrite : StReadIssue;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) state_d = StResp;
        else                  idx_d   = idx_q + 1'b1;
      end
      StReadIssue: begin
        wait_d  = '0;
        state_d = StReadWait;
      end
      StReadWait: begin
        if (capture) begin
          rdata_d[8*idx_q +: 8] = sram_dout;
          if (idx_q == LastIdx) begin
            state_d = StResp;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StReadIssue;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are registered from the upcoming state so strobes line up with state cycles.
  always_comb begin
    wen_d   = (state_d == StWrite);
    sense_d = (state_d == StReadIssue);
    din_d   = wen_d ? wdata_d[8*idx_d +: 8] : 8'h00;
    addr_d  = (wen_d || sense_d) ? base_d + ADDR_W'(idx_d) : addr_q;
  end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Directed bench for sram_line_ctrl: a latency-2 SRAM model and per-scenario cycle-exact checks
// of strobes, addresses, data and response handshake.
module tb_sram_line_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [8:0]  sram_addr;
  logic [7:0]  sram_din;
  logic        sram_wen;
  logic        sram_sense_en;
  logic [7:0]  sram_dout;

  int checks = 0;
  int fails  = 0;

  sram_line_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_wen     (sram_wen),
    .sram_sense_en(sram_sense_en),
    .sram_dout    (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: data is only valid in the second cycle after the sense_en cycle.
  logic [7:0] mem [512];
  logic [1:0] pv;
  logic [8:0] pa0, pa1;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_din;
    if (rst) pv <= 2'b00;
    else     pv <= {pv[0], sram_sense_en};
    pa0 <= sram_addr;
    pa1 <= pa0;
  end
  assign sram_dout = pv[1] ? mem[pa1] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    step();
    checks++;
    if ({req_ready, resp_valid, resp_rdata, sram_addr, sram_din, sram_wen, sram_sense_en} !== '0)
      begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h a=%h din=%h wen=%b se=%b, want all 0",
               req_ready, resp_valid, resp_rdata, sram_addr, sram_din, sram_wen, sram_sense_en);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after: req_ready=%b, want 1", req_ready);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({req_ready, resp_valid, sram_wen, sram_sense_en} !== 4'b1000) begin
        fails++;
        $display("FAIL idle_cycle%0d: rdy=%b rv=%b wen=%b se=%b, want 1 0 0 0",
                 c, req_ready, resp_valid, sram_wen, sram_sense_en);
      end
    end
  endtask

  task automatic test_write(input logic [8:0] a, input logic [31:0] d);
    logic [8:0] b;
    b = a & 9'h1FC;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL write_ready: req_ready=%b, want 1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sram_wen, sram_sense_en, sram_addr, sram_din} !== {2'b10, b + 9'(i), d[8*i +: 8]})
        begin
        fails++;
        $display("FAIL write_byte%0d: wen=%b se=%b a=%h din=%h, want 1 0 %h %h",
                 i, sram_wen, sram_sense_en, sram_addr, sram_din, b + 9'(i), d[8*i +: 8]);
      end
      step();
    end
    checks++;
    if ({resp_valid, resp_rdata, sram_wen, sram_din} !== {1'b1, 32'h0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL write_resp: rv=%b rd=%h wen=%b din=%h, want 1 00000000 0 00",
               resp_valid, resp_rdata, sram_wen, sram_din);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, sram_wen, sram_sense_en} !== 4'b0100) begin
      fails++;
      $display("FAIL write_handshake: rv=%b rdy=%b wen=%b se=%b, want 0 1 0 0",
               resp_valid, req_ready, sram_wen, sram_sense_en);
    end
  endtask

  task automatic test_read(input logic [8:0] a, input logic [31:0] exp, input int hold);
    logic [8:0] b;
    logic       exp_s;
    b = a & 9'h1FC;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL read_ready: req_ready=%b, want 1", req_ready);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_s = ((k - 1) % 3 == 0);
      checks++;
      if (sram_wen !== 1'b0 || sram_sense_en !== exp_s || resp_valid !== 1'b0 ||
          (exp_s && sram_addr !== b + 9'((k - 1) / 3))) begin
        fails++;
        $display("FAIL read_cycle%0d: wen=%b se=%b rv=%b a=%h, want 0 %b 0 %h",
                 k, sram_wen, sram_sense_en, resp_valid, sram_addr, exp_s, b + 9'((k - 1) / 3));
      end
      step();
    end
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, exp}) begin
      fails++;
      $display("FAIL read_resp: rv=%b rd=%h, want 1 %h", resp_valid, resp_rdata, exp);
    end
    for (int h = 0; h < hold; h++) begin
      req_valid = (h == 1); req_write = 1'b1; req_addr = 9'h040; req_wdata = 32'h5555_5555;
      step();
      req_valid = 1'b0;
      checks++;
      if ({resp_valid, resp_rdata, req_ready, sram_wen, sram_sense_en} !== {1'b1, exp, 3'b000})
        begin
        fails++;
        $display("FAIL backpressure%0d: rv=%b rd=%h rdy=%b wen=%b se=%b, want 1 %h 0 0 0",
                 h, resp_valid, resp_rdata, req_ready, sram_wen, sram_sense_en, exp);
      end
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, sram_wen, sram_sense_en} !== 4'b0100) begin
      fails++;
      $display("FAIL read_handshake: rv=%b rdy=%b wen=%b se=%b, want 0 1 0 0",
               resp_valid, req_ready, sram_wen, sram_sense_en);
    end
  endtask

  task automatic test_reset_mid_read();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h010;
    step();
    req_valid = 1'b0;
    for (int k = 1; k < 7; k++) step();
    checks++;
    if ({sram_sense_en, sram_addr} !== {1'b1, 9'h012}) begin
      fails++;
      $display("FAIL midrst_issue2: se=%b a=%h, want 1 012", sram_sense_en, sram_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({sram_wen, sram_sense_en, resp_valid, req_ready, sram_addr, resp_rdata} !==
        {4'b0001, 9'h000, 32'h0}) begin
      fails++;
      $display("FAIL midrst_after: wen=%b se=%b rv=%b rdy=%b a=%h rd=%h, want 0 0 0 1 000 0",
               sram_wen, sram_sense_en, resp_valid, req_ready, sram_addr, resp_rdata);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({sram_wen, sram_sense_en, resp_valid} !== 3'b000) begin
        fails++;
        $display("FAIL midrst_quiet%0d: wen=%b se=%b rv=%b, want 0 0 0",
                 c, sram_wen, sram_sense_en, resp_valid);
      end
    end
    test_read(9'h010, 32'hDDCC_BBAA, 0);
  endtask

  initial begin
    test_reset();
    test_write(9'h010, 32'hDDCC_BBAA);
    test_read(9'h010, 32'hDDCC_BBAA, 0);
    test_read(9'h013, 32'hDDCC_BBAA, 0);
    test_write(9'h1FC, 32'h0403_0201);
    test_read(9'h1FC, 32'h0403_0201, 0);
    test_read(9'h010, 32'hDDCC_BBAA, 5);
    test_read(9'h1FE, 32'h0403_0201, 0);
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
